// File: rtl/cmd_pkg.sv
// Shared definitions for the UART register-access protocol
// (command master and command interpreter).
package cmd_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CMD_WR_BIT = 7;

    localparam logic [DATA_W-1:0] ERR_BYTE_DFLT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_DATA,
        WAIT_RX,
        DONE
    } state_t;

    function automatic logic [DATA_W-1:0] cmd_byte(
        input logic              wr,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] b;
        b             = {1'b0, addr};
        b[CMD_WR_BIT] = wr;
        return b;
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Clearable saturating cycle counter; flags the cycle in which the
// count reaches TIMEOUT_CYCLES-1.
module cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] EXP_AT = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Raised in the cycle whose edge takes the count to LAST.
    assign o_expire = i_en && (r_count >= EXP_AT);

endmodule

// File: rtl/cmd_master.sv
// Initiator side of the single-byte UART register protocol: serialises
// read/write requests to bytes and returns the read-response byte.
module cmd_master
    import cmd_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter logic [DATA_W-1:0] ERR_BYTE       = ERR_BYTE_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    input  logic              i_tx_ready,
    input  logic              i_rx_valid,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_rx_stray,
    output logic              o_busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rx_stray;

    logic              w_latch;
    logic              w_tx_valid;
    logic [DATA_W-1:0] w_tx_data;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_rdata;
    logic              w_rsp_err;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_expire;

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_tx_valid  = r_tx_valid;
        w_tx_data   = r_tx_data;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_latch     = 1'b1;
                    w_tx_valid  = 1'b1;
                    w_tx_data   = cmd_byte(i_req_wr, i_req_addr);
                    w_state_nxt = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (i_tx_ready) begin
                    if (r_wr) begin
                        w_tx_data   = r_wdata;
                        w_state_nxt = SEND_DATA;
                    end else begin
                        w_tx_valid  = 1'b0;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = WAIT_RX;
                    end
                end
            end
            SEND_DATA: begin
                if (i_tx_ready) begin
                    w_tx_valid  = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = '0;
                    w_rsp_err   = 1'b0;
                    w_state_nxt = DONE;
                end
            end
            WAIT_RX: begin
                w_cnt_en = 1'b1;
                // A byte landing in the expiry cycle still wins.
                if (i_rx_valid) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = i_rx_data;
                    w_rsp_err   = 1'b0;
                    w_state_nxt = DONE;
                end else if (w_expire) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = ERR_BYTE;
                    w_rsp_err   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rx_stray  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_valid  <= w_tx_valid;
            r_tx_data   <= w_tx_data;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_rx_stray  <= i_rx_valid && (r_state != WAIT_RX);
            if (w_latch) begin
                r_wr    <= i_req_wr;
                r_wdata <= i_req_wdata;
            end
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_tx_valid  = r_tx_valid;
    assign o_tx_data   = r_tx_data;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_rx_stray  = r_rx_stray;

endmodule
